// File: rtl/pc_source_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the PC-source controller.
//   pc_src_e       PC mux select encodings
//   instr_class_e  committed-instruction classes (5..7 reserved)
//   ctrl_state_e   controller FSM states
//   exc_code_e     resolved exception code
//   VEC_OFF_*      vector-area offsets from VEC_BASE
//   resolve_exc    priority resolution opcode > overflow > divzero
//   vec_offset     exception code -> vector offset
package pc_ctrl_pkg;

  localparam int unsigned MAX_LAT = 4;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    PC_ALU    = 3'd0,
    PC_ALUOUT = 3'd1,
    PC_DESLOC = 3'd2,
    PC_JR     = 3'd3,
    PC_EPC    = 3'd4,
    PC_ROTINA = 3'd5
  } pc_src_e;

  typedef enum logic [2:0] {
    IC_SEQ    = 3'd0,
    IC_BRANCH = 3'd1,
    IC_JUMP   = 3'd2,
    IC_JR     = 3'd3,
    IC_RTE    = 3'd4
  } instr_class_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMMIT    = 3'd1,
    EXC_START = 3'd2,
    EXC_WAIT  = 3'd3,
    EXC_LOAD  = 3'd4,
    EXC_JUMP  = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'd0,
    EXC_OPCODE = 2'd1,
    EXC_OVF    = 2'd2,
    EXC_DIVZ   = 2'd3
  } exc_code_e;

  localparam logic [7:0] VEC_OFF_OPCODE = 8'd0;
  localparam logic [7:0] VEC_OFF_OVF    = 8'd1;
  localparam logic [7:0] VEC_OFF_DIVZ   = 8'd2;

  // Reserved classes (5..7) are treated as an invalid opcode.
  function automatic exc_code_e resolve_exc(input logic [2:0] cls,
                                            input logic       op,
                                            input logic       ovf,
                                            input logic       dz);
    if (op || (cls > 3'd4)) return EXC_OPCODE;
    else if (ovf)           return EXC_OVF;
    else if (dz)            return EXC_DIVZ;
    else                    return EXC_NONE;
  endfunction

  function automatic logic [7:0] vec_offset(input exc_code_e code);
    case (code)
      EXC_OVF:  return VEC_OFF_OVF;
      EXC_DIVZ: return VEC_OFF_DIVZ;
      default:  return VEC_OFF_OPCODE;
    endcase
  endfunction

endpackage

// File: rtl/pc_source_ctrl_if.sv
// pc_source_ctrl_if: request, PC-control and vector-memory signals of the
// PC-source controller.
//   slave  : controller side (receives start/flags/vec_data, drives PC controls)
//   master : main control FSM / memory side
interface pc_source_ctrl_if;
  import pc_ctrl_pkg::*;

  logic        start;
  logic [2:0]  instr_class;
  logic        branch_taken;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_divzero;
  logic [7:0]  vec_data;
  logic [2:0]  PCSource;
  logic        PCWrite;
  logic        EPCWrite;
  logic        vec_read;
  logic [7:0]  vec_addr;
  logic [31:0] RotinaDeTratamentoAddress;
  logic        busy;
  logic        done;

  modport slave (
    input  start, instr_class, branch_taken, exc_opcode, exc_overflow,
           exc_divzero, vec_data,
    output PCSource, PCWrite, EPCWrite, vec_read, vec_addr,
           RotinaDeTratamentoAddress, busy, done
  );

  modport master (
    output start, instr_class, branch_taken, exc_opcode, exc_overflow,
           exc_divzero, vec_data,
    input  PCSource, PCWrite, EPCWrite, vec_read, vec_addr,
           RotinaDeTratamentoAddress, busy, done
  );

endinterface

// File: rtl/pc_source_ctrl_lat_counter.sv
// lat_counter: loadable down-counter used to time memory read latency.
//   clk, reset : clock, synchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (no underflow below zero)
//   zero       : count == 0
module lat_counter #(
  parameter int unsigned MAX_LAT = 4,
  parameter int unsigned W       = $clog2(MAX_LAT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl: turns a one-cycle commit request plus exception flags into
// a timed PC update (PCSource/PCWrite/EPCWrite). On an exception it writes
// EPC, reads the handler byte from the vector area and jumps to it.
//   clk    : system clock
//   reset  : synchronous, active-low
//   bus    : pc_source_ctrl_if.slave (request inputs, vector memory, PC controls,
//            busy/done, RotinaDeTratamentoAddress)
// MEM_LAT (1..4) is the vec_read -> vec_data latency in cycles.
module pc_source_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter logic [7:0]  VEC_BASE = 8'hFD
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_source_ctrl_if.slave       bus
);

  localparam logic [LAT_W-1:0] WAIT_LOAD = LAT_W'(MEM_LAT - 1);

  ctrl_state_e state, state_nxt;
  logic [2:0]  cls_q;
  logic        taken_q;
  exc_code_e   exc_q;
  exc_code_e   exc_in;
  logic [7:0]  handler_q;
  logic        lat_zero;

  logic [2:0]  pcsrc_d;
  logic        pcw_d;
  logic        epcw_d;
  logic        vread_d;
  logic [7:0]  vaddr_d;
  logic        done_d;

  assign exc_in = resolve_exc(bus.instr_class, bus.exc_opcode,
                              bus.exc_overflow, bus.exc_divzero);

  // Loaded with MEM_LAT-1 on EXC_START so EXC_WAIT lasts exactly MEM_LAT cycles.
  lat_counter #(
    .MAX_LAT (MAX_LAT),
    .W       (LAT_W)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (state == EXC_START),
    .load_val (WAIT_LOAD),
    .dec      (state == EXC_WAIT),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cls_q     <= '0;
      taken_q   <= 1'b0;
      exc_q     <= EXC_NONE;
      handler_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && bus.start) begin
        cls_q   <= bus.instr_class;
        taken_q <= bus.branch_taken;
        exc_q   <= exc_in;
      end
      if (state == EXC_LOAD) begin
        handler_q <= bus.vec_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = (exc_in != EXC_NONE) ? EXC_START : COMMIT;
      COMMIT:    state_nxt = IDLE;
      EXC_START: state_nxt = EXC_WAIT;
      EXC_WAIT:  if (lat_zero) state_nxt = EXC_LOAD;
      EXC_LOAD:  state_nxt = EXC_JUMP;
      EXC_JUMP:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pcsrc_d = PC_ALU;
    pcw_d   = 1'b0;
    epcw_d  = 1'b0;
    vread_d = 1'b0;
    vaddr_d = '0;
    done_d  = 1'b0;
    case (state)
      COMMIT: begin
        done_d = 1'b1;
        case (cls_q)
          IC_SEQ:    begin pcsrc_d = PC_ALU;    pcw_d = 1'b1;    end
          IC_BRANCH: begin pcsrc_d = PC_ALUOUT; pcw_d = taken_q; end
          IC_JUMP:   begin pcsrc_d = PC_DESLOC; pcw_d = 1'b1;    end
          IC_JR:     begin pcsrc_d = PC_JR;     pcw_d = 1'b1;    end
          IC_RTE:    begin pcsrc_d = PC_EPC;    pcw_d = 1'b1;    end
          default:   begin pcsrc_d = PC_ALU;    pcw_d = 1'b0;    end
        endcase
      end
      EXC_START: begin
        epcw_d  = 1'b1;
        vread_d = 1'b1;
        vaddr_d = VEC_BASE + vec_offset(exc_q);
      end
      EXC_JUMP: begin
        pcsrc_d = PC_ROTINA;
        pcw_d   = 1'b1;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is low so an aborted sequence never
  // issues a write in the reset cycle itself.
  assign bus.PCSource                  = pcsrc_d;
  assign bus.PCWrite                   = pcw_d & reset;
  assign bus.EPCWrite                  = epcw_d & reset;
  assign bus.vec_read                  = vread_d & reset;
  assign bus.vec_addr                  = vaddr_d;
  assign bus.done                      = done_d;
  assign bus.busy                      = (state != IDLE);
  assign bus.RotinaDeTratamentoAddress = {24'b0, handler_q};

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Scoreboard bench for pc_source_ctrl: two instances (MEM_LAT=1 and 3)
// share request inputs, each with its own vector memory model.
module tb_pc_source_ctrl;
  import pc_ctrl_pkg::*;

  typedef struct {
    logic [2:0]  cls;
    logic        tk, op, ov, dz;
    logic [2:0]  pcs;
    logic        pcw, exc;
    logic [7:0]  vaddr;
    logic [31:0] rot;
  } vec_t;

  typedef struct {
    logic [2:0]  pcs;
    logic        pcw, exc;
    logic [7:0]  vaddr;
    logic [31:0] rot;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_r = 1'b0;
  int   sel = 0;
  logic [2:0] cls_r = '0;
  logic tk_r = 1'b0, op_r = 1'b0, ov_r = 1'b0, dz_r = 1'b0;

  int nchecks = 0;
  int nfail = 0;
  int ml[2] = '{1, 3};

  exp_t q0[$];
  exp_t q1[$];

  int   bcnt[2], pcwt[2], epct[2], rdat[2];
  logic [7:0] rdaddr[2];
  bit   rdseen[2];

  vec_t tbl[12];

  always #5 clk = ~clk;

  pc_source_ctrl_if b1();
  pc_source_ctrl_if b3();

  assign b1.start        = start_r & (sel == 0);
  assign b3.start        = start_r & (sel == 1);
  assign b1.instr_class  = cls_r;
  assign b3.instr_class  = cls_r;
  assign b1.branch_taken = tk_r;
  assign b3.branch_taken = tk_r;
  assign b1.exc_opcode   = op_r;
  assign b3.exc_opcode   = op_r;
  assign b1.exc_overflow = ov_r;
  assign b3.exc_overflow = ov_r;
  assign b1.exc_divzero  = dz_r;
  assign b3.exc_divzero  = dz_r;

  pc_source_ctrl #(.MEM_LAT(1), .VEC_BASE(8'hFD)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  pc_source_ctrl #(.MEM_LAT(3), .VEC_BASE(8'hFD)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  function automatic logic [7:0] memv(input logic [7:0] a);
    case (a)
      8'hFD:   return 8'hA7;
      8'hFE:   return 8'h5C;
      8'hFF:   return 8'h3E;
      default: return 8'h00;
    endcase
  endfunction

  // Vector memory models: data appears MEM_LAT cycles after vec_read and holds.
  logic [7:0] d1 = '0, d3 = '0;
  logic       r3a = 1'b0, r3b = 1'b0;
  logic [7:0] a3a = '0, a3b = '0;
  assign b1.vec_data = d1;
  assign b3.vec_data = d3;
  always @(posedge clk) begin
    if (b1.vec_read) d1 <= memv(b1.vec_addr);
    r3a <= b3.vec_read; a3a <= b3.vec_addr;
    r3b <= r3a;         a3b <= a3a;
    if (r3b) d3 <= memv(a3b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [2:0] cls, input logic tk, op, ov, dz,
                               input logic [2:0] pcs, input logic pcw, exc,
                               input logic [7:0] vaddr, input logic [31:0] rot);
    vec_t v;
    v.cls = cls; v.tk = tk; v.op = op; v.ov = ov; v.dz = dz;
    v.pcs = pcs; v.pcw = pcw; v.exc = exc; v.vaddr = vaddr; v.rot = rot;
    return v;
  endfunction

  task automatic push(input int k, input vec_t v);
    exp_t e;
    e.pcs = v.pcs; e.pcw = v.pcw; e.exc = v.exc; e.vaddr = v.vaddr; e.rot = v.rot;
    e.lat = v.exc ? ml[k] + 3 : 1;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic set_in(input vec_t v);
    cls_r = v.cls; tk_r = v.tk; op_r = v.op; ov_r = v.ov; dz_r = v.dz;
  endtask

  task automatic issue(input int k, input vec_t v);
    sel = k;
    set_in(v);
    push(k, v);
    start_r = 1'b1;
    tick;
    start_r = 1'b0;
  endtask

  function automatic logic busy_of(input int k);
    return (k == 0) ? b1.busy : b3.busy;
  endfunction

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_of(k) && n < 40) begin
      tick;
      n++;
    end
    if (n >= 40) begin
      nchecks++;
      nfail++;
      $display("FAIL wait_idle inst=%0d actual=busy required=idle", k);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    if (k == 0) begin
      chk({tag, "_pcsource1"}, 32'(b1.PCSource), 32'd0);
      chk({tag, "_strobes1"}, {28'd0, b1.PCWrite, b1.EPCWrite, b1.vec_read, b1.done}, 32'd0);
      chk({tag, "_busy1"}, 32'(b1.busy), 32'd0);
      chk({tag, "_vaddr1"}, 32'(b1.vec_addr), 32'd0);
      chk({tag, "_handler1"}, b1.RotinaDeTratamentoAddress, 32'd0);
    end else begin
      chk({tag, "_pcsource3"}, 32'(b3.PCSource), 32'd0);
      chk({tag, "_strobes3"}, {28'd0, b3.PCWrite, b3.EPCWrite, b3.vec_read, b3.done}, 32'd0);
      chk({tag, "_busy3"}, 32'(b3.busy), 32'd0);
      chk({tag, "_vaddr3"}, 32'(b3.vec_addr), 32'd0);
      chk({tag, "_handler3"}, b3.RotinaDeTratamentoAddress, 32'd0);
    end
  endtask

  // Monitor: tracks each transaction from busy rising to done, then compares.
  task automatic mon(input int k, input logic busy, done, pcw, epcw, vread,
                     input logic [2:0] pcs, input logic [7:0] vaddr, input logic [31:0] rot);
    exp_t e;
    if (!reset) begin
      bcnt[k] = 0; pcwt[k] = 0; epct[k] = 0; rdseen[k] = 0; rdat[k] = 0;
      return;
    end
    if (pcw || epcw) chk($sformatf("pcw_epcw_exclusive%0d", k), 32'(pcw & epcw), 32'd0);
    if (busy) bcnt[k]++;
    if (pcw) pcwt[k]++;
    if (epcw) epct[k]++;
    if (vread) begin
      rdseen[k] = 1; rdat[k] = bcnt[k]; rdaddr[k] = vaddr;
    end
    if (done) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        nchecks++;
        nfail++;
        $display("FAIL unexpected_done inst=%0d actual=done required=no_request", k);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("pcsource%0d", k), 32'(pcs), 32'(e.pcs));
        chk($sformatf("pcwrite_count%0d", k), 32'(pcwt[k]), 32'(e.pcw));
        chk($sformatf("latency%0d", k), 32'(bcnt[k]), 32'(e.lat));
        chk($sformatf("exc_path%0d", k), 32'(rdseen[k]), 32'(e.exc));
        if (e.exc) begin
          chk($sformatf("vec_addr%0d", k), 32'(rdaddr[k]), 32'(e.vaddr));
          chk($sformatf("epc_cycle%0d", k), 32'(rdat[k]), 32'd1);
          chk($sformatf("epc_count%0d", k), 32'(epct[k]), 32'd1);
          chk($sformatf("handler%0d", k), rot, e.rot);
        end else begin
          chk($sformatf("epc_count%0d", k), 32'(epct[k]), 32'd0);
        end
      end
      bcnt[k] = 0; pcwt[k] = 0; epct[k] = 0; rdseen[k] = 0; rdat[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, b1.busy, b1.done, b1.PCWrite, b1.EPCWrite, b1.vec_read, b1.PCSource,
        b1.vec_addr, b1.RotinaDeTratamentoAddress);
    mon(1, b3.busy, b3.done, b3.PCWrite, b3.EPCWrite, b3.vec_read, b3.PCSource,
        b3.vec_addr, b3.RotinaDeTratamentoAddress);
  end

  // Spam start every cycle of an exception sequence; only the start in the
  // cycle after done is accepted.
  task automatic spam(input int k, input vec_t ev, input vec_t sv);
    sel = k;
    set_in(ev);
    push(k, ev);
    start_r = 1'b1;
    tick;
    set_in(sv);
    for (int i = 0; i < ml[k] + 3; i++) tick;
    push(k, sv);
    tick;
    start_r = 1'b0;
    wait_idle(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             cls   tk    op    ov    dz    pcs   pcw   exc   vaddr  rot
    tbl[0]  = mkv(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 32'h0);
    tbl[1]  = mkv(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'h00, 32'h0);
    tbl[2]  = mkv(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 32'h0);
    tbl[3]  = mkv(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'h00, 32'h0);
    tbl[4]  = mkv(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 32'h0);
    tbl[5]  = mkv(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'h00, 32'h0);
    tbl[6]  = mkv(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 8'hFE, 32'h5C);
    tbl[7]  = mkv(3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFD, 32'hA7);
    tbl[8]  = mkv(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'hFD, 32'hA7);
    tbl[9]  = mkv(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFF, 32'h3E);
    tbl[10] = mkv(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFE, 32'h5C);
    tbl[11] = mkv(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 8'hFD, 32'hA7);

    reset = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    #1;
    chk_idle(0, "reset");
    chk_idle(1, "reset");

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 12; i++) begin
        issue(k, tbl[i]);
        wait_idle(k);
      end
    end

    spam(0, tbl[9], tbl[0]);
    spam(1, tbl[9], tbl[0]);

    // Reset in the middle of EXC_WAIT of the MEM_LAT=3 instance.
    issue(1, tbl[6]);
    tick;
    chk("mid_wait_busy", 32'(b3.busy), 32'd1);
    reset = 1'b0;
    void'(q1.pop_back());
    tick;
    reset = 1'b1;
    #1;
    chk_idle(1, "abort");
    repeat (2) tick;
    issue(1, tbl[0]);
    wait_idle(1);

    repeat (3) tick;
    chk("queue_empty1", 32'(q0.size()), 32'd0);
    chk("queue_empty3", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
